// File: rtl/hash_io_pkg.sv
// Shared types and sizing helpers for the hash I/O bridge and its read mux.
package hash_io_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT} state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_BLOCK_W  = 512;
  localparam int DEF_DIGEST_W = 256;

  function automatic int word_cnt(int total_w, int word_w);
    return total_w / word_w;
  endfunction

  // At least one address bit even for a single-word target
  function automatic int addr_w(int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/hash_io_rdmux.sv
// Registered DATA_W-wide slice read from a wide register; out-of-range or disabled reads return 0.
module hash_io_rdmux
  import hash_io_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TOTAL_W = DEF_DIGEST_W,
  parameter int ADDR_W  = addr_w(word_cnt(DEF_DIGEST_W, DEF_DATA_W)) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [TOTAL_W-1:0] i_data,
  output logic [DATA_W-1:0]  o_data
);

  localparam int WORDS = word_cnt(TOTAL_W, DATA_W);

  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] r_data;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (i_addr == ADDR_W'(k)) w_sel = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_data <= '0;
    else        r_data <= i_en ? w_sel : '0;
  end

  assign o_data = r_data;

endmodule

// File: rtl/hash_io_bridge.sv
// Word-serial load/unload bridge between a narrow bus and a wide-block hash core.
// Optional macro HASH_IO_AUTO_INC_EN: internal write pointer replaces wr_addr/wr_last.
module hash_io_bridge
  import hash_io_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BLOCK_W  = DEF_BLOCK_W,
  parameter int DIGEST_W = DEF_DIGEST_W
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          wr_en,
  input  logic [addr_w(word_cnt(BLOCK_W, DATA_W))-1:0]  wr_addr,
  input  logic [DATA_W-1:0]                             wr_data,
  input  logic                                          wr_last,
  input  logic                                          msg_end,
  output logic                                          wr_drop,
  output logic                                          busy,
  input  logic [addr_w(word_cnt(DIGEST_W, DATA_W)):0]   rd_addr,
  output logic [DATA_W-1:0]                             rd_data,
  output logic                                          digest_valid,
  output logic [BLOCK_W-1:0]                            core_block,
  output logic                                          core_start,
  output logic                                          core_first,
  input  logic                                          core_ready,
  input  logic [DIGEST_W-1:0]                           core_digest
);

  localparam int WORDS_IN  = word_cnt(BLOCK_W, DATA_W);
  localparam int WORDS_OUT = word_cnt(DIGEST_W, DATA_W);
  localparam int IN_AW     = addr_w(WORDS_IN);
  localparam int OUT_AW    = addr_w(WORDS_OUT) + 1;

  state_t               r_state;
  logic [BLOCK_W-1:0]   r_block;
  logic [DIGEST_W-1:0]  r_dig;
  logic                 r_end;
  logic                 r_first;
  logic                 r_dvalid;
  logic                 r_drop;
  logic                 r_start;
  logic                 r_cfirst;

  logic                 w_acc;
  logic                 w_last;
  logic [IN_AW-1:0]     w_idx;

  assign w_acc = wr_en && (r_state == ST_LOAD);

`ifdef HASH_IO_AUTO_INC_EN
  logic [IN_AW-1:0] r_wptr;
  logic             w_unused;

  assign w_idx    = r_wptr;
  assign w_last   = (r_wptr == IN_AW'(WORDS_IN - 1));
  assign w_unused = ^{wr_addr, wr_last};

  // WORDS_IN is a power of two, so the natural rollover is the wrap to 0
  always_ff @(posedge clk) begin
    if (!rst_n)     r_wptr <= '0;
    else if (w_acc) r_wptr <= r_wptr + 1'b1;
  end
`else
  assign w_idx  = wr_addr;
  assign w_last = wr_last;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_LOAD;
      r_block  <= '0;
      r_dig    <= '0;
      r_end    <= 1'b0;
      r_first  <= 1'b1;
      r_dvalid <= 1'b0;
      r_drop   <= 1'b0;
      r_start  <= 1'b0;
      r_cfirst <= 1'b0;
    end else begin
      r_drop <= wr_en && (r_state != ST_LOAD);
      case (r_state)
        ST_LOAD: begin
          if (w_acc) begin
            for (int k = 0; k < WORDS_IN; k++) begin
              if (w_idx == IN_AW'(k)) r_block[k*DATA_W +: DATA_W] <= wr_data;
            end
            // First word of a new message retires the previous digest
            if (r_first) r_dvalid <= 1'b0;
            if (w_last) begin
              r_end    <= msg_end;
              r_start  <= 1'b1;
              r_cfirst <= r_first;
              r_state  <= ST_START;
            end
          end
        end
        ST_START: begin
          r_start  <= 1'b0;
          r_cfirst <= 1'b0;
          r_first  <= r_end;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_ready) begin
            r_dig   <= core_digest;
            if (r_end) r_dvalid <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  hash_io_rdmux #(
    .DATA_W (DATA_W),
    .TOTAL_W(DIGEST_W),
    .ADDR_W (OUT_AW)
  ) u_rdmux (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_dvalid),
    .i_addr(rd_addr),
    .i_data(r_dig),
    .o_data(rd_data)
  );

  assign busy         = (r_state != ST_LOAD);
  assign wr_drop      = r_drop;
  assign digest_valid = r_dvalid;
  assign core_block   = r_block;
  assign core_start   = r_start;
  assign core_first   = r_cfirst;

endmodule

// File: tb/tb_hash_io_bridge.sv
// Directed bench for hash_io_bridge with a scripted core: checks load, chaining, back-pressure, readout and reset.
module tb_hash_io_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         wr_last = 1'b0;
  logic         msg_end = 1'b0;
  logic         wr_drop;
  logic         busy;
  logic [5:0]   rd_addr = '0;
  logic [7:0]   rd_data;
  logic         digest_valid;
  logic [511:0] core_block;
  logic         core_start;
  logic         core_first;
  logic         core_ready = 1'b0;
  logic [255:0] core_digest = '0;

  int n_tot  = 0;
  int n_pass = 0;

  localparam logic [255:0] DIG_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_MID  = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
  localparam logic [255:0] DIG_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [511:0] blk;

  hash_io_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .msg_end     (msg_end),
    .wr_drop     (wr_drop),
    .busy        (busy),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .digest_valid(digest_valid),
    .core_block  (core_block),
    .core_start  (core_start),
    .core_first  (core_first),
    .core_ready  (core_ready),
    .core_digest (core_digest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input int addr, input logic [7:0] data, input logic last, input logic mend);
    wr_en   = 1'b1;
    wr_addr = 6'(addr);
    wr_data = data;
    wr_last = last;
    msg_end = mend;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
    msg_end = 1'b0;
  endtask

  task automatic load_block(input logic [511:0] b, input logic mend);
    for (int k = 0; k < 64; k++) wr(k, b[k*8 +: 8], k == 63, mend);
  endtask

  task automatic core_done(input logic [255:0] d);
    core_ready  = 1'b1;
    core_digest = d;
    tick();
    core_ready  = 1'b0;
    core_digest = '0;
  endtask

  task automatic rd(input int addr, input string tag, input logic [7:0] exp);
    rd_addr = 6'(addr);
    tick();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    // Reset defaults
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_dvalid", digest_valid, 0);
    chk("rst_start", core_start, 0);
    chk("rst_first", core_first, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_drop", wr_drop, 0);
    rst_n = 1'b1;
    tick();

    // Single-block "abc"
    blk = '0;
    blk[7:0] = 8'h61; blk[15:8] = 8'h62; blk[23:16] = 8'h63; blk[31:24] = 8'h80;
    blk[511:504] = 8'h18;
    load_block(blk, 1'b1);
    chk("abc_start", core_start, 1);
    chk("abc_first", core_first, 1);
    chk("abc_busy", busy, 1);
    chk("abc_block", core_block, blk);
    core_done(DIG_ABC);
    chk("ready_in_start_ignored", busy, 1);
    chk("abc_start_pulse", core_start, 0);

    // Back-pressure in WAIT
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("drop_pulse", wr_drop, 1);
    tick();
    chk("drop_once", wr_drop, 0);
    chk("drop_block5", core_block[47:40], 8'h00);

    core_done(DIG_ABC);
    chk("abc_busy_low", busy, 0);
    chk("abc_dvalid", digest_valid, 1);

    // Readout
    rd(31, "rd31", 8'hba);
    rd(0, "rd0", 8'had);
    rd(1, "rd1", 8'h15);
    rd(32, "rd32", 8'h00);
    rd(30, "rd30", 8'h78);

    // Two-block chain
    for (int k = 0; k < 64; k++) blk[k*8 +: 8] = 8'(k);
    wr(0, blk[7:0], 1'b0, 1'b0);
    chk("chain_clear_dvalid", digest_valid, 0);
    rd(31, "rd_invalid", 8'h00);
    for (int k = 1; k < 64; k++) wr(k, blk[k*8 +: 8], k == 63, 1'b0);
    chk("chain1_start", core_start, 1);
    chk("chain1_first", core_first, 1);
    chk("chain1_block", core_block, blk);
    tick();
    core_done(DIG_MID);
    chk("chain1_dvalid", digest_valid, 0);
    rd(0, "chain1_rd", 8'h00);
    for (int k = 0; k < 64; k++) blk[k*8 +: 8] = 8'hFF - 8'(k);
    load_block(blk, 1'b1);
    chk("chain2_start", core_start, 1);
    chk("chain2_first", core_first, 0);
    chk("chain2_word5", core_block[47:40], 8'hFA);
    tick();
    core_done(DIG_TWO);
    chk("chain2_dvalid", digest_valid, 1);
    rd(31, "chain2_rd31", 8'h24);
    rd(0, "chain2_rd0", 8'hc1);

    // Reset mid-operation
    wr(0, 8'h11, 1'b1, 1'b1);
    chk("mid_dvalid_cleared", digest_valid, 0);
    tick();
    chk("mid_busy_wait", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy_after_rst", busy, 0);
    core_done(DIG_ABC);
    chk("late_ready_dvalid", digest_valid, 0);
    chk("late_ready_busy", busy, 0);
    rd(31, "late_ready_rd", 8'h00);
    wr(3, 8'h33, 1'b1, 1'b1);
    chk("post_rst_start", core_start, 1);
    chk("post_rst_first", core_first, 1);
    chk("post_rst_block", core_block, 512'h33 << 24);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
